// File: rtl/replay_pkg.sv
// Shared types and helpers for the ping-pong replay buffer sequencer.
//   replay_state_t : replay FSM encoding
//   idx_w()        : index width for a given bank depth (one spare bit)
//   is_grst_state(), is_read_state(), stream_of() : state decode helpers
package replay_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRST0 = 3'd1,
    RD0   = 3'd2,
    GRST1 = 3'd3,
    RD1   = 3'd4
  } replay_state_t;

  // Index width: one bit wider than needed to address the bank.
  function automatic int unsigned idx_w(input int unsigned depth);
    return 32'($clog2(depth)) + 32'd1;
  endfunction

  // States that pulse the column gamma reset.
  function automatic logic is_grst_state(input replay_state_t s);
    return (s == GRST0) || (s == GRST1);
  endfunction

  // States that present a replay beat to the column.
  function automatic logic is_read_state(input replay_state_t s);
    return (s == RD0) || (s == RD1);
  endfunction

  // Stream owning the state: 0 = data_in1, 1 = data_in2.
  function automatic logic stream_of(input replay_state_t s);
    return (s == GRST1) || (s == RD1);
  endfunction

endpackage

// File: rtl/replay_idx_counter.sv
// Bank index counter: synchronous clear, count enable, saturates at DEPTH-1.
//   clk, rstb : clock and synchronous active-low reset
//   clr       : force index to 0 (wins over en)
//   en        : advance by one unless already at DEPTH-1
//   idx       : registered index
//   at_last_c : idx == DEPTH-1 (combinational decode of idx)
module replay_idx_counter #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             at_last_c
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  assign at_last_c = (idx == LAST_IDX);

  // Index register; holds at the last entry so it never exceeds DEPTH-1.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en && !at_last_c) begin
      idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/replay_buffer_ctrl.sv
// Sequencer for a two-input ping-pong replay buffer feeding one multiplexed
// column. Each gamma cycle it captures spikes into one bank, swaps banks on
// the gamma boundary, and replays the filled bank to the column twice
// (stream 0 then stream 1), each pass preceded by a one-cycle column reset.
//   clk, rstb   : clock, synchronous active-low reset
//   grst        : gamma reset; rising edge marks a gamma boundary
//   col_ready   : column accepts the presented beat this cycle
//   wr_en       : capture bank write enable
//   wr_idx      : capture bank write address
//   buf_sel     : 1 = write bank0/read bank1, 0 = write bank1/read bank0
//   rd_idx      : replay read address
//   mux_sel     : stream being replayed
//   rd_valid    : rd_idx/mux_sel carry a valid beat
//   col_grst    : one-cycle column gamma reset before each stream
//   replay_done : one-cycle pulse after the last stream-1 beat is accepted
//   overrun_err : sticky, gamma boundary seen while a replay was running
module replay_buffer_ctrl
  import replay_pkg::*;
#(
  parameter  int unsigned BUFFER_DEPTH = 16,
  parameter  int unsigned NUM_INPUTS   = 2,
  localparam int unsigned IDX_W        = idx_w(BUFFER_DEPTH)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             grst,
  input  logic             col_ready,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic             buf_sel,
  output logic [IDX_W-1:0] rd_idx,
  output logic             mux_sel,
  output logic             rd_valid,
  output logic             col_grst,
  output logic             replay_done,
  output logic             overrun_err
);

  if (NUM_INPUTS != 2) begin : g_bad_num_inputs
    $error("replay_buffer_ctrl supports exactly two multiplexed inputs");
  end

  replay_state_t state;
  replay_state_t state_d;

  logic grst_q;
  logic grst_armed;
  logic active;
  logic gstart;
  logic capture_full;
  logic wr_at_last;
  logic rd_at_last;
  logic rd_accept;
  logic rd_last_accept;

  logic col_grst_d;
  logic rd_valid_d;
  logic mux_sel_d;
  logic replay_done_d;

  // grst_armed blocks a false boundary when grst is already high at reset
  // release; it arms once grst has been seen low.
  assign gstart         = grst & ~grst_q & grst_armed;
  // The bank about to be read holds a complete capture.
  assign capture_full   = active & ~wr_en;
  assign rd_accept      = is_read_state(state) & col_ready;
  assign rd_last_accept = rd_accept & rd_at_last;

  // Edge detect, activity flag, bank swap and sticky overrun.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      grst_q      <= 1'b0;
      grst_armed  <= 1'b0;
      active      <= 1'b0;
      buf_sel     <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      grst_q     <= grst;
      grst_armed <= grst_armed | ~grst;
      if (gstart) begin
        active  <= 1'b1;
        buf_sel <= ~buf_sel;
      end
      if (gstart && (state != IDLE)) begin
        overrun_err <= 1'b1;
      end
    end
  end

  // Capture write enable: one full bank per gamma cycle, then idle.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_en <= 1'b0;
    end else if (gstart) begin
      wr_en <= 1'b1;
    end else if (wr_en && wr_at_last) begin
      wr_en <= 1'b0;
    end
  end

  replay_idx_counter #(
    .DEPTH (BUFFER_DEPTH),
    .IDX_W (IDX_W)
  ) u_wr_cnt (
    .clk       (clk),
    .rstb      (rstb),
    .clr       (gstart),
    .en        (wr_en),
    .idx       (wr_idx),
    .at_last_c (wr_at_last)
  );

  // Read index restarts for each stream and on every gamma boundary, so it
  // is 0 whenever no beat is being presented.
  replay_idx_counter #(
    .DEPTH (BUFFER_DEPTH),
    .IDX_W (IDX_W)
  ) u_rd_cnt (
    .clk       (clk),
    .rstb      (rstb),
    .clr       (gstart | rd_last_accept),
    .en        (rd_accept),
    .idx       (rd_idx),
    .at_last_c (rd_at_last)
  );

  // Replay state register.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state: a gamma boundary restarts (or cancels) the replay from any state.
  always_comb begin
    state_d = state;
    if (gstart) begin
      state_d = capture_full ? GRST0 : IDLE;
    end else begin
      unique case (state)
        IDLE:    state_d = IDLE;
        GRST0:   state_d = RD0;
        RD0:     if (rd_last_accept) state_d = GRST1;
        GRST1:   state_d = RD1;
        RD1:     if (rd_last_accept) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so the outputs are registered.
  always_comb begin
    col_grst_d    = is_grst_state(state_d);
    rd_valid_d    = is_read_state(state_d);
    mux_sel_d     = stream_of(state_d);
    replay_done_d = (state == RD1) & rd_last_accept & ~gstart;
  end

  // Registered replay outputs.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      col_grst    <= 1'b0;
      rd_valid    <= 1'b0;
      mux_sel     <= 1'b0;
      replay_done <= 1'b0;
    end else begin
      col_grst    <= col_grst_d;
      rd_valid    <= rd_valid_d;
      mux_sel     <= mux_sel_d;
      replay_done <= replay_done_d;
    end
  end

endmodule
